bin_to_bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter (shift-add-3 / double-dabble). It is the reverse path of the BCD-to-binary/Gray front end.
- Accepts a WIDTH-bit value that is either plain binary or Gray-coded. Produces DIGITS packed BCD digits plus an overflow flag.
- Uses valid/ready handshakes on both sides. Sits between binary datapath results and BCD display/report logic.

---
 rtl/bin_to_bcd_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
//
// Sequential binary-to-BCD converter using shift-add-3 (double dabble).
// The input word is either plain binary or Gray-coded; Gray input is decoded
// to binary as it is captured. One input bit is consumed per clock, so a
// conversion takes WIDTH shift steps after the accept edge.
//
// Ports:
//   clk_i        clock, all state changes on the rising edge
//   rst_i        asynchronous active-high reset
//   in_valid_i   input word present
//   in_ready_o   block can accept a word (idle)
//   dat_i        input word, WIDTH bits
//   gray_i       1: dat_i is Gray-coded, 0: plain binary
//   out_valid_o  result available (done)
//   out_ready_i  consumer takes the result
//   dat_bcd_o    packed BCD result, digit k (units = 0) in bits [4k+3:4k]
//   ovf_o        value exceeded 10^DIGITS-1; dat_bcd_o holds the low digits
// ---------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [WIDTH-1:0]      dat_i,
    input  logic                  gray_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [4*DIGITS-1:0]   dat_bcd_o,
    output logic                  ovf_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int ACC_W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b            = '0;
        b[WIDTH-1]   = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Double-dabble correction: any digit >= 5 gets +3 so the coming shift
    // carries correctly into the next decimal digit.
    function automatic logic [ACC_W-1:0] add3_digits(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] r;
        logic [3:0]       d;
        r = '0;
        for (int k = 0; k < DIGITS; k++) begin
            d = a[4*k +: 4];
            if (d >= 4'd5) begin
                r[4*k +: 4] = d + 4'd3;
            end else begin
                r[4*k +: 4] = d;
            end
        end
        return r;
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               in_ready_nxt_s;
    logic               out_valid_nxt_s;

    logic [WIDTH-1:0]   shreg_r;
    logic [ACC_W-1:0]   acc_r;
    logic               ovf_sticky_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [ACC_W-1:0]   dat_bcd_r;
    logic               ovf_r;

    logic [ACC_W-1:0]   acc_adj_s;
    logic [ACC_W-1:0]   acc_shift_s;
    logic [WIDTH-1:0]   shreg_shift_s;
    logic               carry_out_s;
    logic               last_step_s;

    // State register and registered handshake flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= in_ready_nxt_s;
            out_valid_r <= out_valid_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid_i) begin
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_step_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output decode of the upcoming state, so the flags are registered and
    // always equal the state the block is in.
    always_comb begin
        in_ready_nxt_s  = 1'b0;
        out_valid_nxt_s = 1'b0;
        case (state_nxt_s)
            IDLE: begin
                in_ready_nxt_s  = 1'b1;
                out_valid_nxt_s = 1'b0;
            end
            SHIFT: begin
                in_ready_nxt_s  = 1'b0;
                out_valid_nxt_s = 1'b0;
            end
            DONE: begin
                in_ready_nxt_s  = 1'b0;
                out_valid_nxt_s = 1'b1;
            end
            default: begin
                in_ready_nxt_s  = 1'b0;
                out_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // One shift-add-3 step: correct, then shift {acc, shreg} left by one.
    // The bit leaving the accumulator top is a carry worth 10^DIGITS.
    always_comb begin
        acc_adj_s     = add3_digits(acc_r);
        carry_out_s   = acc_adj_s[ACC_W-1];
        acc_shift_s   = {acc_adj_s[ACC_W-2:0], shreg_r[WIDTH-1]};
        shreg_shift_s = {shreg_r[WIDTH-2:0], 1'b0};
        last_step_s   = (cnt_r == CNT_W'(1));
    end

    // Conversion datapath and result registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shreg_r      <= '0;
            acc_r        <= '0;
            ovf_sticky_r <= 1'b0;
            cnt_r        <= '0;
            dat_bcd_r    <= '0;
            ovf_r        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid_i) begin
                        if (gray_i) begin
                            shreg_r <= gray_to_bin(dat_i);
                        end else begin
                            shreg_r <= dat_i;
                        end
                        acc_r        <= '0;
                        ovf_sticky_r <= 1'b0;
                        cnt_r        <= CNT_W'(WIDTH);
                    end
                end
                SHIFT: begin
                    shreg_r      <= shreg_shift_s;
                    acc_r        <= acc_shift_s;
                    ovf_sticky_r <= ovf_sticky_r | carry_out_s;
                    cnt_r        <= cnt_r - CNT_W'(1);
                    // Publish on the final step, folding in its own carry-out.
                    if (last_step_s) begin
                        dat_bcd_r <= acc_shift_s;
                        ovf_r     <= ovf_sticky_r | carry_out_s;
                    end
                end
                DONE: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_r;
    assign out_valid_o = out_valid_r;
    assign dat_bcd_o   = dat_bcd_r;
    assign ovf_o       = ovf_r;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// Testbench for bin_to_bcd_seq. Two instances (3 and 2 digits) share the
// same stimulus. An arithmetic model predicts handshake flags and results;
// directed conversions also check hand-computed literals and latency.
// ---------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

    localparam int W = 8;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [W-1:0] dat;
    logic        gray;
    logic        out_ready;

    logic        in_ready3, out_valid3, ovf3;
    logic [11:0] bcd3;
    logic        in_ready2, out_valid2, ovf2;
    logic [7:0]  bcd2;

    int checks;
    int failures;

    bin_to_bcd_seq #(.WIDTH(W), .DIGITS(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready3),
        .dat_i(dat), .gray_i(gray), .out_valid_o(out_valid3),
        .out_ready_i(out_ready), .dat_bcd_o(bcd3), .ovf_o(ovf3)
    );

    bin_to_bcd_seq #(.WIDTH(W), .DIGITS(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready2),
        .dat_i(dat), .gray_i(gray), .out_valid_o(out_valid2),
        .out_ready_i(out_ready), .dat_bcd_o(bcd2), .ovf_o(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int decode(input logic [W-1:0] d, input logic g);
        int v;
        int x;
        v = int'(d);
        if (g) begin
            x = v;
            for (int s = 1; s < W; s++) x = x ^ (v >> s);
            v = x;
        end
        return v;
    endfunction

    function automatic logic [11:0] to_bcd(input int v, input int nd);
        logic [11:0] r;
        int t;
        r = 12'h000;
        t = v;
        for (int k = 0; k < nd; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    int          m_phase;    // 0 idle, 1 converting, 2 result held
    int          m_edges;
    int          m_val;
    logic [11:0] m_bcd3;
    logic [7:0]  m_bcd2;
    logic        m_ovf3, m_ovf2;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_edges <= 0;
            m_val   <= 0;
            m_bcd3  <= 12'h000;
            m_bcd2  <= 8'h00;
            m_ovf3  <= 1'b0;
            m_ovf2  <= 1'b0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_val   <= decode(dat, gray);
                    m_edges <= 0;
                    m_phase <= 1;
                end
                1: begin
                    m_edges <= m_edges + 1;
                    if (m_edges + 1 == W) begin
                        m_phase <= 2;
                        m_bcd3  <= to_bcd(m_val, 3);
                        m_bcd2  <= to_bcd(m_val, 2)[7:0];
                        m_ovf3  <= (m_val > 999);
                        m_ovf2  <= (m_val > 99);
                    end
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready3",  {31'd0, in_ready3},  {31'd0, m_phase == 0});
            chk("out_valid3", {31'd0, out_valid3}, {31'd0, m_phase == 2});
            chk("in_ready2",  {31'd0, in_ready2},  {31'd0, m_phase == 0});
            chk("out_valid2", {31'd0, out_valid2}, {31'd0, m_phase == 2});
            chk("bcd3", {20'd0, bcd3}, {20'd0, m_bcd3});
            chk("ovf3", {31'd0, ovf3}, {31'd0, m_ovf3});
            chk("bcd2", {24'd0, bcd2}, {24'd0, m_bcd2});
            chk("ovf2", {31'd0, ovf2}, {31'd0, m_ovf2});
            for (int k = 0; k < 3; k++) begin
                chk("digit_range", {31'd0, bcd3[4*k +: 4] <= 4'd9}, 32'd1);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic accept(input logic [W-1:0] d, input logic g);
        chk("ready_before_accept", {31'd0, in_ready3}, 32'd1);
        in_valid = 1'b1;
        dat      = d;
        gray     = g;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dat      = 8'hA5;
        gray     = 1'b1;
    endtask

    // Count edges after the accept edge until out_valid rises (bounded).
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid3) begin
                n = i;
                break;
            end
        end
        chk("latency", n, W);
    endtask

    task automatic convert(input logic [W-1:0] d, input logic g,
                           input logic [11:0] e3, input logic [7:0] e2,
                           input logic eovf2);
        int n;
        out_ready = 1'b1;
        accept(d, g);
        wait_done(n);
        chk("lit_bcd3", {20'd0, bcd3}, {20'd0, e3});
        chk("lit_ovf3", {31'd0, ovf3}, 32'd0);
        chk("lit_bcd2", {24'd0, bcd2}, {24'd0, e2});
        chk("lit_ovf2", {31'd0, ovf2}, {31'd0, eovf2});
        @(posedge clk);
        #1;
        chk("ready_after_hs", {31'd0, in_ready3}, 32'd1);
        chk("hold_after_hs", {20'd0, bcd3}, {20'd0, e3});
    endtask

    initial begin
        int n;
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        dat       = 8'h00;
        gray      = 1'b0;
        out_ready = 1'b1;

        #1;
        chk("rst_in_ready",  {31'd0, in_ready3},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid3}, 32'd0);
        chk("rst_bcd",       {20'd0, bcd3},       32'd0);
        chk("rst_ovf",       {31'd0, ovf3},       32'd0);

        // Pin the model itself with hand-derived values.
        chk("model_gray255", decode(8'b1000_0000, 1'b1), 255);
        chk("model_gray19",  decode(8'b0001_1010, 1'b1), 19);
        chk("model_bcd255",  {20'd0, to_bcd(255, 3)}, 32'h255);
        chk("model_bcd100_2", {20'd0, to_bcd(100, 2)}, 32'h000);

        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        convert(8'd255, 1'b0, 12'h255, 8'h55, 1'b1);
        convert(8'b1000_0000, 1'b1, 12'h255, 8'h55, 1'b1);
        convert(8'b0001_1010, 1'b1, 12'h019, 8'h19, 1'b0);
        convert(8'd0,   1'b0, 12'h000, 8'h00, 1'b0);
        convert(8'd9,   1'b0, 12'h009, 8'h09, 1'b0);
        convert(8'd10,  1'b0, 12'h010, 8'h10, 1'b0);
        convert(8'd99,  1'b0, 12'h099, 8'h99, 1'b0);
        convert(8'd100, 1'b0, 12'h100, 8'h00, 1'b1);
        convert(8'd99,  1'b0, 12'h099, 8'h99, 1'b0);
        convert(8'd128, 1'b0, 12'h128, 8'h28, 1'b1);

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        accept(8'd42, 1'b0);
        wait_done(n);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            dat      = 8'd77;
            gray     = 1'b0;
            @(posedge clk);
            #1;
            chk("bp_bcd",       {20'd0, bcd3},       32'h042);
            chk("bp_out_valid", {31'd0, out_valid3}, 32'd1);
            chk("bp_in_ready",  {31'd0, in_ready3},  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_ready", {31'd0, in_ready3}, 32'd1);
        chk("bp_release_bcd",   {20'd0, bcd3},      32'h042);

        // Reset mid-conversion discards the work and clears the outputs.
        accept(8'd200, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready",  {31'd0, in_ready3},  32'd1);
        chk("mid_rst_out_valid", {31'd0, out_valid3}, 32'd0);
        chk("mid_rst_bcd",       {20'd0, bcd3},       32'd0);
        chk("mid_rst_ovf",       {31'd0, ovf3},       32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        convert(8'd7, 1'b0, 12'h007, 8'h07, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
